// File: rtl/uart_rx_fifo_if.sv
// Bus-side bundle of the UART receiver: serial input, pop/clear strobes,
// FIFO head and status. The receiver takes the slave view, the bus the master view.
interface uart_rx_fifo_if;
    logic       rx;
    logic       rd;
    logic       clr;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovf;
    logic       busy;

    modport master (
        output rx, rd, clr,
        input  data, valid, ferr, ovf, busy
    );

    modport slave (
        input  rx, rd, clr,
        output data, valid, ferr, ovf, busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO and sticky framing/overflow flags.
// The serial input is resynchronised; bit timing comes from a fixed clocks-per-bit divider.
module uart_rx_fifo #(
    parameter int DIV   = 868,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] MID_CNT = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_CNT = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    logic          rx_p0;
    logic          rs;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          busy_q;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   rptr_nxt;
    logic [7:0]    data_q;
    logic          ferr_q;
    logic          ovf_q;

    logic bit_tick;
    logic push;
    logic frame_err;
    logic empty;
    logic full;
    logic pop;
    logic push_ok;
    logic ovf_set;

    // Two-flop resynchroniser; idles high so reset never looks like a start edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_p0 <= 1'b1;
            rs    <= 1'b1;
        end else begin
            rx_p0 <= bus.rx;
            rs    <= rx_p0;
        end
    end

    assign bit_tick  = (cnt == BIT_CNT);
    assign push      = (state == STOP) && bit_tick && rs;
    assign frame_err = (state == STOP) && bit_tick && !rs;

    // Receiver FSM: start qualification at mid-bit, 8 data samples, stop check, break wait
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rs) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == MID_CNT) begin
                        cnt <= '0;
                        if (rs) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (rs) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= BRK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BRK: begin
                    cnt <= '0;
                    if (rs) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Data shift register, LSB first; holds the complete byte when the stop bit is sampled
    always_ff @(posedge clk) begin
        if (state == DATA && bit_tick) begin
            shreg <= {rs, shreg[7:1]};
        end
    end

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop      = bus.rd && !empty;
    assign push_ok  = push && (!full || pop);
    assign ovf_set  = push && full && !pop;
    assign rptr_nxt = pop ? rptr + PTR_ONE : rptr;

    // FIFO storage, written only when the push is accepted
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= shreg;
        end
    end

    // FIFO pointers, registered head read and sticky flags (set wins over clr)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr   <= '0;
            rptr   <= '0;
            data_q <= '0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            rptr <= rptr_nxt;
            // A byte landing in a slot that becomes the head must bypass the memory
            if (push_ok && (rptr_nxt == wptr)) begin
                data_q <= shreg;
            end else if (pop) begin
                data_q <= mem[rptr_nxt[AW-1:0]];
            end
            ferr_q <= frame_err | (ferr_q & ~bus.clr);
            ovf_q  <= ovf_set | (ovf_q & ~bus.clr);
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = !empty;
    assign bus.ferr  = ferr_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = busy_q;
endmodule
